// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and per-opcode settle latency
// for the ALU command issuer.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_FLS = 3'd4;
   localparam logic [2:0] OP_FRS = 3'd5;
   localparam logic [2:0] OP_RLS = 3'd6;
   localparam logic [2:0] OP_RRS = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } alu_state_t;

   // Cycles from accept to capture; divide-by-zero never waits for the ALU.
   function automatic logic [3:0] alu_latency(input logic [2:0] op,
                                               input logic       b_zero,
                                               input logic [3:0] settle);
      if (op == OP_ADD || op == OP_SUB)
         return 4'd1;
      if (op == OP_DIV && b_zero)
         return 4'd1;
      return settle;
   endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-drive, response and status bundle of the ALU command issuer.
interface alu_cmd_issuer_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [2:0]  cmd_opcode;
   logic [5:0]  cmd_shift;
   logic [3:0]  cmd_tag;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_opcode;
   logic [5:0]  alu_shift;
   logic [63:0] alu_out;
   logic        alu_carry;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_carry;
   logic [3:0]  rsp_tag;
   logic        rsp_err;

   logic        busy;
   logic [15:0] op_count;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_shift, cmd_tag,
      output cmd_ready,
      output alu_a, alu_b, alu_opcode, alu_shift,
      input  alu_out, alu_carry,
      output rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_err,
      input  rsp_ready,
      output busy, op_count
   );

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_shift, cmd_tag,
      input  cmd_ready,
      input  alu_a, alu_b, alu_opcode, alu_shift,
      output alu_out, alu_carry,
      input  rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_err,
      output rsp_ready,
      input  busy, op_count
   );

endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to an external combinational ALU, waits a
// per-opcode settle time, then captures and holds the result as a response.
//
// state     | meaning
// ST_IDLE   | no transaction, ready for a command
// ST_SETTLE | ALU inputs driven, counting down to capture
// ST_RESP   | response held until rsp_ready
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4  // legal range 2..15
) (
   input logic              clk,
   input logic              rst_n,
   alu_cmd_issuer_if.slave  bus
);

   localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES);

   alu_state_t  r_state;
   alu_state_t  w_state_nxt;
   logic [3:0]  r_cnt;
   logic        r_div0;
   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic [2:0]  r_alu_opcode;
   logic [5:0]  r_alu_shift;
   logic [63:0] r_rsp_data;
   logic        r_rsp_carry;
   logic [3:0]  r_rsp_tag;
   logic        r_rsp_err;
   logic [15:0] r_op_count;

   logic        w_cmd_ready;
   logic        w_accept;
   logic        w_capture;
   logic        w_rsp_hs;
   logic        w_b_zero;
   logic [3:0]  w_cnt_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_ready = 1'b0;
      w_capture   = 1'b0;
      w_rsp_hs    = 1'b0;
      case (r_state)
         ST_IDLE: w_cmd_ready = 1'b1;
         ST_SETTLE: begin
            if (r_cnt == 4'd0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               w_rsp_hs    = 1'b1;
               w_cmd_ready = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_accept = bus.cmd_valid && w_cmd_ready;
      if (w_accept)
         w_state_nxt = ST_SETTLE;
   end

   assign w_b_zero   = (bus.cmd_b == 32'd0);
   assign w_cnt_load = alu_latency(bus.cmd_opcode, w_b_zero, SETTLE_N) - 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= 4'd0;
         r_div0       <= 1'b0;
         r_alu_a      <= 32'd0;
         r_alu_b      <= 32'd0;
         r_alu_opcode <= 3'd0;
         r_alu_shift  <= 6'd0;
         r_rsp_data   <= 64'd0;
         r_rsp_carry  <= 1'b0;
         r_rsp_tag    <= 4'd0;
         r_rsp_err    <= 1'b0;
         r_op_count   <= 16'd0;
      end else begin
         if (w_accept) begin
            r_alu_a      <= bus.cmd_a;
            r_alu_b      <= bus.cmd_b;
            r_alu_opcode <= bus.cmd_opcode;
            r_alu_shift  <= bus.cmd_shift;
            r_rsp_tag    <= bus.cmd_tag;
            r_div0       <= (bus.cmd_opcode == OP_DIV) && w_b_zero;
            r_cnt        <= w_cnt_load;
         end else if (r_state == ST_SETTLE && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end

         // Divide-by-zero answers with a fixed error pattern, not the ALU.
         if (w_capture) begin
            if (r_div0) begin
               r_rsp_data  <= '1;
               r_rsp_carry <= 1'b0;
               r_rsp_err   <= 1'b1;
            end else begin
               r_rsp_data  <= bus.alu_out;
               r_rsp_carry <= bus.alu_carry;
               r_rsp_err   <= 1'b0;
            end
         end

         if (w_rsp_hs && r_op_count != 16'hFFFF)
            r_op_count <= r_op_count + 16'd1;
      end
   end

   assign bus.cmd_ready  = w_cmd_ready;
   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign bus.alu_opcode = r_alu_opcode;
   assign bus.alu_shift  = r_alu_shift;
   assign bus.rsp_valid  = (r_state == ST_RESP);
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_carry  = r_rsp_carry;
   assign bus.rsp_tag    = r_rsp_tag;
   assign bus.rsp_err    = r_rsp_err;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.op_count   = r_op_count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU on the alu_* bus.
module tb_alu_cmd_issuer;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   alu_cmd_issuer_if bus();

   alu_cmd_issuer #(.SETTLE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [32:0] w_sum33;
   logic [32:0] w_dif33;
   always_comb begin
      w_sum33       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      w_dif33       = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      bus.alu_out   = 64'd0;
      bus.alu_carry = 1'b0;
      case (bus.alu_opcode)
         OP_ADD: begin
            bus.alu_out   = {31'd0, w_sum33};
            bus.alu_carry = w_sum33[32];
         end
         OP_SUB: begin
            bus.alu_out   = {32'd0, w_dif33[31:0]};
            bus.alu_carry = w_dif33[32];
         end
         OP_MUL: bus.alu_out = 64'(bus.alu_a) * 64'(bus.alu_b);
         OP_DIV: bus.alu_out = (bus.alu_b == 32'd0) ? 64'h0000_DEAD_0000_BEEF
                                                    : {32'd0, bus.alu_a / bus.alu_b};
         OP_FLS: bus.alu_out = {32'd0, bus.alu_a << bus.alu_shift};
         OP_FRS: bus.alu_out = {32'd0, bus.alu_a >> bus.alu_shift};
         default: bus.alu_out = 64'd0;
      endcase
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer a command 1 ns after an edge; it is accepted on the next edge.
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] sh, input logic [3:0] tag);
      bus.cmd_opcode = op;
      bus.cmd_a      = a;
      bus.cmd_b      = b;
      bus.cmd_shift  = sh;
      bus.cmd_tag    = tag;
      bus.cmd_valid  = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid  = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!bus.rsp_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   int lat;
   int seen;

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst_n          = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_a      = 32'd0;
      bus.cmd_b      = 32'd0;
      bus.cmd_opcode = 3'd0;
      bus.cmd_shift  = 6'd0;
      bus.cmd_tag    = 4'd0;
      bus.rsp_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_eq("rst_busy",      64'(bus.busy),      64'd0);
      check_eq("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check_eq("rst_op_count",  64'(bus.op_count),  64'd0);
      check_eq("rst_rsp_data",  bus.rsp_data,       64'd0);
      rst_n = 1'b1;

      // ADD with carry out, accepted on the first edge after reset release
      send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 6'd0, 4'd3);
      check_eq("add_busy", 64'(bus.busy), 64'd1);
      wait_rsp(lat);
      check_eq("add_lat",   64'(lat),           64'd1);
      check_eq("add_data",  bus.rsp_data,       64'h1_0000_0000);
      check_eq("add_carry", 64'(bus.rsp_carry), 64'd1);
      check_eq("add_tag",   64'(bus.rsp_tag),   64'd3);
      check_eq("add_err",   64'(bus.rsp_err),   64'd0);
      step();
      check_eq("add_opcnt", 64'(bus.op_count),  64'd1);
      check_eq("add_idle",  64'(bus.busy),      64'd0);

      send(OP_MUL, 32'd6, 32'd7, 6'd0, 4'd1);
      wait_rsp(lat);
      check_eq("mul_lat",   64'(lat),            64'd4);
      check_eq("mul_data",  bus.rsp_data,        64'd42);
      check_eq("mul_hold",  64'(bus.alu_opcode), 64'(OP_MUL));
      step();

      send(OP_DIV, 32'd100, 32'd0, 6'd0, 4'd2);
      wait_rsp(lat);
      check_eq("div0_lat",   64'(lat),           64'd1);
      check_eq("div0_err",   64'(bus.rsp_err),   64'd1);
      check_eq("div0_data",  bus.rsp_data,       64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("div0_carry", 64'(bus.rsp_carry), 64'd0);
      step();

      send(OP_DIV, 32'd100, 32'd7, 6'd0, 4'd4);
      wait_rsp(lat);
      check_eq("div_lat",  64'(lat),         64'd4);
      check_eq("div_data", bus.rsp_data,     64'd14);
      check_eq("div_err",  64'(bus.rsp_err), 64'd0);
      step();
      check_eq("div_opcnt", 64'(bus.op_count), 64'd4);

      // Stalled response, a new command waiting meanwhile, then back-to-back
      bus.rsp_ready = 1'b0;
      send(OP_SUB, 32'd10, 32'd3, 6'd0, 4'd5);
      wait_rsp(lat);
      check_eq("sub_lat",  64'(lat),     64'd1);
      check_eq("sub_data", bus.rsp_data, 64'd7);
      bus.cmd_opcode = OP_FLS;
      bus.cmd_a      = 32'd1;
      bus.cmd_b      = 32'd0;
      bus.cmd_shift  = 6'd4;
      bus.cmd_tag    = 4'd9;
      bus.cmd_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_eq("stall_valid", 64'(bus.rsp_valid), 64'd1);
         check_eq("stall_data",  bus.rsp_data,       64'd7);
         check_eq("stall_tag",   64'(bus.rsp_tag),   64'd5);
         check_eq("stall_carry", 64'(bus.rsp_carry), 64'd0);
         check_eq("stall_err",   64'(bus.rsp_err),   64'd0);
         check_eq("stall_ready", 64'(bus.cmd_ready), 64'd0);
         check_eq("stall_alu_a", 64'(bus.alu_a),     64'd10);
      end
      bus.rsp_ready = 1'b1;
      #1;
      check_eq("b2b_ready", 64'(bus.cmd_ready), 64'd1);
      step();
      bus.cmd_valid = 1'b0;
      check_eq("b2b_rsp_valid", 64'(bus.rsp_valid),  64'd0);
      check_eq("b2b_busy",      64'(bus.busy),       64'd1);
      check_eq("b2b_alu_a",     64'(bus.alu_a),      64'd1);
      check_eq("b2b_alu_op",    64'(bus.alu_opcode), 64'(OP_FLS));
      check_eq("b2b_alu_sh",    64'(bus.alu_shift),  64'd4);
      check_eq("b2b_opcnt",     64'(bus.op_count),   64'd5);
      wait_rsp(lat);
      check_eq("fls_lat",  64'(lat),           64'd4);
      check_eq("fls_data", bus.rsp_data,       64'd16);
      check_eq("fls_tag",  64'(bus.rsp_tag),   64'd9);
      step();
      check_eq("fls_opcnt", 64'(bus.op_count), 64'd6);

      // Reset in the middle of a MUL settle
      send(OP_MUL, 32'd6, 32'd7, 6'd0, 4'd6);
      step();
      check_eq("mid_busy", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mrst_busy",      64'(bus.busy),      64'd0);
      check_eq("mrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_eq("mrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check_eq("mrst_alu_a",     64'(bus.alu_a),     64'd0);
      check_eq("mrst_alu_op",    64'(bus.alu_opcode), 64'd0);
      check_eq("mrst_rsp_data",  bus.rsp_data,       64'd0);
      check_eq("mrst_rsp_tag",   64'(bus.rsp_tag),   64'd0);
      check_eq("mrst_opcnt",     64'(bus.op_count),  64'd0);
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.rsp_valid || bus.busy) seen++;
      end
      check_eq("no_stale",    64'(seen),         64'd0);
      check_eq("post_opcnt",  64'(bus.op_count), 64'd0);

      // op_count saturation
      force dut.r_op_count = 16'hFFFE;
      step();
      release dut.r_op_count;
      check_eq("sat_preload", 64'(bus.op_count), 64'hFFFE);
      for (int i = 0; i < 3; i++) begin
         send(OP_ADD, 32'(i), 32'd1, 6'd0, 4'd0);
         wait_rsp(lat);
         check_eq("sat_lat", 64'(lat), 64'd1);
         step();
         check_eq("sat_opcnt", 64'(bus.op_count), 64'hFFFF);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
